// File: rtl/fir_axi_lite_driver_if.sv
// AXI4-Lite bus bundle between the FIR driver (master) and the accelerator's register slave.
interface fir_axi_lite_driver_if #(
    parameter int unsigned C_ADDR_WIDTH = 5,
    parameter int unsigned C_DATA_WIDTH = 32
) ();
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/fir_axi_lite_driver.sv
// AXI4-Lite master that configures the FIR accelerator (tap count, coefficients, enable)
// and then streams samples through it: write X, poll STATUS, read Y, present Y downstream.
module fir_axi_lite_driver #(
    parameter int unsigned C_MAX_TAPS   = 16,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH = 5,
    parameter int unsigned C_POLL_LIMIT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start_i,
    input  logic [7:0]              cfg_taps_i,
    input  logic [C_DATA_WIDTH-1:0] coeff_tdata_i,
    input  logic                    coeff_tvalid_i,
    output logic                    coeff_tready_o,
    input  logic [C_DATA_WIDTH-1:0] x_tdata_i,
    input  logic                    x_tvalid_i,
    output logic                    x_tready_o,
    output logic [C_DATA_WIDTH-1:0] y_tdata_o,
    output logic                    y_tvalid_o,
    input  logic                    y_tready_i,
    output logic                    busy_o,
    output logic                    error_o,
    fir_axi_lite_driver_if.master   m_axi
);

    localparam int unsigned PW = $clog2(C_POLL_LIMIT + 1);
    localparam logic [7:0]  MaxTaps = 8'(C_MAX_TAPS);
    localparam logic [PW-1:0] PollLast = PW'(C_POLL_LIMIT - 1);

    localparam logic [C_ADDR_WIDTH-1:0] AddrCtrl   = C_ADDR_WIDTH'(8'h00);
    localparam logic [C_ADDR_WIDTH-1:0] AddrTaps   = C_ADDR_WIDTH'(8'h04);
    localparam logic [C_ADDR_WIDTH-1:0] AddrCoeff  = C_ADDR_WIDTH'(8'h08);
    localparam logic [C_ADDR_WIDTH-1:0] AddrX      = C_ADDR_WIDTH'(8'h0C);
    localparam logic [C_ADDR_WIDTH-1:0] AddrStatus = C_ADDR_WIDTH'(8'h10);
    localparam logic [C_ADDR_WIDTH-1:0] AddrY      = C_ADDR_WIDTH'(8'h14);

    typedef enum logic [3:0] {
        StIdle, StWrTaps, StWrCoeff, StWrCtrl, StPollLoad,
        StGetX, StWrX, StPollY, StRdY, StOutY, StErr
    } state_e;

    state_e                  state_q;
    logic [7:0]              n_q;
    logic [7:0]              cnt_q;
    logic [PW-1:0]           poll_q;
    logic [C_ADDR_WIDTH-1:0] awaddr_q;
    logic                    awvalid_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;
    logic                    wvalid_q;
    logic                    wr_pend_q;
    logic                    bready_q;
    logic [C_ADDR_WIDTH-1:0] araddr_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    coeff_tready_q;
    logic                    x_tready_q;
    logic [C_DATA_WIDTH-1:0] y_tdata_q;
    logic                    y_tvalid_q;
    logic                    busy_q;
    logic                    error_q;

    logic [7:0] taps_clamped;
    logic       aw_done;
    logic       w_done;
    logic       b_fire;
    logic       r_fire;
    logic       bus_err;

    assign taps_clamped = (cfg_taps_i > MaxTaps) ? MaxTaps : cfg_taps_i;
    // Address/data phase is finished once valid is low or is being accepted this cycle.
    assign aw_done = !awvalid_q || m_axi.awready;
    assign w_done  = !wvalid_q || m_axi.wready;
    assign b_fire  = m_axi.bvalid && bready_q;
    assign r_fire  = m_axi.rvalid && rready_q;
    assign bus_err = (b_fire && (m_axi.bresp != 2'b00)) || (r_fire && (m_axi.rresp != 2'b00));

    // Main sequencer: bus channel bookkeeping, then per-state transaction launch/completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            n_q            <= '0;
            cnt_q          <= '0;
            poll_q         <= '0;
            awaddr_q       <= '0;
            awvalid_q      <= 1'b0;
            wdata_q        <= '0;
            wvalid_q       <= 1'b0;
            wr_pend_q      <= 1'b0;
            bready_q       <= 1'b0;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            coeff_tready_q <= 1'b0;
            x_tready_q     <= 1'b0;
            y_tdata_q      <= '0;
            y_tvalid_q     <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            if (m_axi.awready) awvalid_q <= 1'b0;
            if (m_axi.wready)  wvalid_q  <= 1'b0;
            if (wr_pend_q && !bready_q && aw_done && w_done) bready_q <= 1'b1;
            if (b_fire) begin
                bready_q  <= 1'b0;
                wr_pend_q <= 1'b0;
            end
            if (arvalid_q && m_axi.arready) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_fire) rready_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (cfg_start_i) begin
                        busy_q    <= 1'b1;
                        n_q       <= taps_clamped;
                        state_q   <= StWrTaps;
                        awaddr_q  <= AddrTaps;
                        wdata_q   <= C_DATA_WIDTH'(taps_clamped);
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        wr_pend_q <= 1'b1;
                    end
                end
                StWrTaps: begin
                    if (b_fire) begin
                        if (n_q == 8'd0) begin
                            state_q   <= StWrCtrl;
                            awaddr_q  <= AddrCtrl;
                            wdata_q   <= C_DATA_WIDTH'(1);
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wr_pend_q <= 1'b1;
                        end else begin
                            state_q        <= StWrCoeff;
                            cnt_q          <= '0;
                            coeff_tready_q <= 1'b1;
                        end
                    end
                end
                StWrCoeff: begin
                    // tready is up only while no COEFF write is in flight
                    if (coeff_tready_q && coeff_tvalid_i) begin
                        coeff_tready_q <= 1'b0;
                        awaddr_q       <= AddrCoeff;
                        wdata_q        <= coeff_tdata_i;
                        awvalid_q      <= 1'b1;
                        wvalid_q       <= 1'b1;
                        wr_pend_q      <= 1'b1;
                    end
                    if (b_fire) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == n_q) begin
                            state_q   <= StWrCtrl;
                            awaddr_q  <= AddrCtrl;
                            wdata_q   <= C_DATA_WIDTH'(1);
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wr_pend_q <= 1'b1;
                        end else begin
                            coeff_tready_q <= 1'b1;
                        end
                    end
                end
                StWrCtrl: begin
                    if (b_fire) begin
                        if (n_q == 8'd0) begin
                            state_q    <= StGetX;
                            x_tready_q <= 1'b1;
                        end else begin
                            state_q   <= StPollLoad;
                            poll_q    <= '0;
                            araddr_q  <= AddrStatus;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StPollLoad, StPollY: begin
                    if (r_fire) begin
                        if ((state_q == StPollLoad) ? m_axi.rdata[1] : m_axi.rdata[0]) begin
                            if (state_q == StPollLoad) begin
                                state_q    <= StGetX;
                                x_tready_q <= 1'b1;
                            end else begin
                                state_q   <= StRdY;
                                araddr_q  <= AddrY;
                                arvalid_q <= 1'b1;
                            end
                        end else if (poll_q == PollLast) begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end else begin
                            poll_q    <= poll_q + 1'b1;
                            araddr_q  <= AddrStatus;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StGetX: begin
                    if (x_tready_q && x_tvalid_i) begin
                        x_tready_q <= 1'b0;
                        state_q    <= StWrX;
                        awaddr_q   <= AddrX;
                        wdata_q    <= x_tdata_i;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        wr_pend_q  <= 1'b1;
                    end
                end
                StWrX: begin
                    if (b_fire) begin
                        state_q   <= StPollY;
                        poll_q    <= '0;
                        araddr_q  <= AddrStatus;
                        arvalid_q <= 1'b1;
                    end
                end
                StRdY: begin
                    if (r_fire) begin
                        state_q    <= StOutY;
                        y_tdata_q  <= m_axi.rdata;
                        y_tvalid_q <= 1'b1;
                    end
                end
                StOutY: begin
                    if (y_tready_i) begin
                        y_tvalid_q <= 1'b0;
                        state_q    <= StGetX;
                        x_tready_q <= 1'b1;
                    end
                end
                StErr: begin
                    awvalid_q      <= 1'b0;
                    wvalid_q       <= 1'b0;
                    wr_pend_q      <= 1'b0;
                    bready_q       <= 1'b0;
                    arvalid_q      <= 1'b0;
                    rready_q       <= 1'b0;
                    coeff_tready_q <= 1'b0;
                    x_tready_q     <= 1'b0;
                    y_tvalid_q     <= 1'b0;
                end
                default: state_q <= StErr;
            endcase

            // A slave error response overrides whatever the state wanted to launch next.
            if (bus_err) begin
                state_q        <= StErr;
                error_q        <= 1'b1;
                awvalid_q      <= 1'b0;
                wvalid_q       <= 1'b0;
                wr_pend_q      <= 1'b0;
                bready_q       <= 1'b0;
                arvalid_q      <= 1'b0;
                rready_q       <= 1'b0;
                coeff_tready_q <= 1'b0;
                x_tready_q     <= 1'b0;
                y_tvalid_q     <= 1'b0;
            end
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign coeff_tready_o = coeff_tready_q;
    assign x_tready_o     = x_tready_q;
    assign y_tdata_o      = y_tdata_q;
    assign y_tvalid_o     = y_tvalid_q;
    assign busy_o         = busy_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_fir_axi_lite_driver.sv
// Bench for fir_axi_lite_driver: AXI-Lite slave model plus coefficient/sample sources,
// with a scoreboard of expected writes, reads and results checked by a monitor.
module tb_fir_axi_lite_driver;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cfg_start = 1'b0;
    logic [7:0]    cfg_taps = '0;
    logic [DW-1:0] coeff_tdata, x_tdata, y_tdata;
    logic          coeff_tvalid, coeff_tready, x_tvalid, x_tready, y_tvalid;
    logic          y_tready = 1'b1;
    logic          busy, error;

    fir_axi_lite_driver_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    fir_axi_lite_driver #(.C_MAX_TAPS(16), .C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW),
                          .C_POLL_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .cfg_start_i(cfg_start), .cfg_taps_i(cfg_taps),
        .coeff_tdata_i(coeff_tdata), .coeff_tvalid_i(coeff_tvalid), .coeff_tready_o(coeff_tready),
        .x_tdata_i(x_tdata), .x_tvalid_i(x_tvalid), .x_tready_o(x_tready),
        .y_tdata_o(y_tdata), .y_tvalid_o(y_tvalid), .y_tready_i(y_tready),
        .busy_o(busy), .error_o(error), .m_axi(bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            awl;
    } wr_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] exp_y[$];
    logic [DW-1:0] coeff_src[$];
    logic [DW-1:0] x_src[$];

    int n_pass = 0;
    int n_total = 0;

    // Slave configuration and observable counters.
    int            aw_delay = 1;
    int            bad_wr_idx = -1;
    int            y_on = 0;
    logic [DW-1:0] y_val = '0;
    int            wr_idx, st_cnt, st_reads, aw_total, ar_total, coeff_used;
    bit            aw_got, w_got;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    bit            busy_watch = 0;
    bit            busy_low_seen = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Slave + stream sources: sample handshakes at negedge, update drive #1 after posedge.
    initial begin : slave
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, c_hs, x_hs;
        logic [AW-1:0] aw_a, ar_a;
        logic [DW-1:0] w_d;
        int aw_cnt;
        aw_cnt = 0;
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
        bus.bresp = 2'b00; bus.rresp = 2'b00; bus.rdata = '0;
        coeff_tvalid = 0; coeff_tdata = '0; x_tvalid = 0; x_tdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready; aw_a = bus.awaddr;
            w_hs  = bus.wvalid && bus.wready;   w_d  = bus.wdata;
            b_hs  = bus.bvalid && bus.bready;
            ar_hs = bus.arvalid && bus.arready; ar_a = bus.araddr;
            r_hs  = bus.rvalid && bus.rready;
            c_hs  = coeff_tvalid && coeff_tready;
            x_hs  = x_tvalid && x_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
                aw_got = 0; w_got = 0; aw_cnt = 0; wr_idx = 0; st_cnt = 0; st_reads = 0;
                aw_total = 0; ar_total = 0; coeff_used = 0;
            end else begin
                if (aw_hs) begin aw_got = 1; cap_addr = aw_a; aw_total++; end
                if (w_hs) begin w_got = 1; cap_data = w_d; end
                if (b_hs) begin
                    bus.bvalid = 0;
                    if (cap_addr == AW'(8'h0C)) st_cnt = 0;
                    aw_got = 0; w_got = 0; wr_idx++;
                end else if (aw_got && w_got && !bus.bvalid) begin
                    bus.bvalid = 1;
                    bus.bresp = (wr_idx == bad_wr_idx) ? 2'b10 : 2'b00;
                end
                if (bus.awvalid && !aw_got) begin
                    aw_cnt++;
                    bus.awready = (aw_cnt >= aw_delay);
                end else begin
                    aw_cnt = 0;
                    bus.awready = 0;
                end
                bus.wready = bus.wvalid;
                if (r_hs) bus.rvalid = 0;
                if (ar_hs) begin
                    ar_total++;
                    bus.rvalid = 1;
                    bus.rresp = 2'b00;
                    if (ar_a == AW'(8'h10)) begin
                        st_cnt++; st_reads++;
                        bus.rdata = 32'h2 | ((y_on != 0 && st_cnt >= y_on) ? 32'h1 : 32'h0);
                    end else if (ar_a == AW'(8'h14)) bus.rdata = y_val;
                    else bus.rdata = '0;
                end
                bus.arready = bus.arvalid;
            end
            if (c_hs && coeff_src.size() > 0) begin void'(coeff_src.pop_front()); coeff_used++; end
            if (x_hs && x_src.size() > 0) void'(x_src.pop_front());
            coeff_tvalid = (coeff_src.size() > 0);
            coeff_tdata  = (coeff_src.size() > 0) ? coeff_src[0] : '0;
            x_tvalid     = (x_src.size() > 0);
            x_tdata      = (x_src.size() > 0) ? x_src[0] : '0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a write, issues a read or
    // hands off a result.
    initial begin : monitor
        int aw_hi, w_hi, aw_len, w_len;
        bit bready_early;
        wr_t e;
        aw_hi = 0; w_hi = 0; aw_len = 0; w_len = 0; bready_early = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_hi = 0; w_hi = 0; bready_early = 0;
            end else begin
                if (busy_watch && !busy) busy_low_seen = 1;
                if (bus.awvalid) aw_hi++;
                if (bus.wvalid) w_hi++;
                if (bus.awvalid && bus.awready) begin aw_len = aw_hi; aw_hi = 0; end
                if (bus.wvalid && bus.wready) begin w_len = w_hi; w_hi = 0; end
                if (bus.bready && !(aw_got && w_got)) bready_early = 1;
                if (bus.bvalid && bus.bready) begin
                    if (exp_wr.size() == 0) check("unexpected_write", 64'(cap_addr), 64'hFFFF);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 64'(cap_addr), 64'(e.a));
                        check("wr_data", 64'(cap_data), 64'(e.d));
                        check("awvalid_cycles", 64'(aw_len), 64'(e.awl));
                        check("wvalid_cycles", 64'(w_len), 64'd1);
                        check("bready_after_both", 64'(bready_early), 64'd0);
                    end
                    bready_early = 0;
                end
                if (bus.arvalid && bus.arready) begin
                    if (exp_rd.size() == 0) check("unexpected_read", 64'(bus.araddr), 64'hFFFF);
                    else check("rd_addr", 64'(bus.araddr), 64'(exp_rd.pop_front()));
                end
                if (y_tvalid && y_tready) begin
                    if (exp_y.size() == 0) check("unexpected_y", 64'(y_tdata), 64'hFFFF_FFFF_F);
                    else check("y_data", 64'(y_tdata), 64'(exp_y.pop_front()));
                end
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = AW'(a); e.d = d; e.awl = aw_delay;
        exp_wr.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        exp_wr.delete(); exp_rd.delete(); exp_y.delete();
        coeff_src.delete(); x_src.delete();
        aw_delay = 1; bad_wr_idx = -1; y_on = 0; y_val = '0; y_tready = 1;
        busy_watch = 0; busy_low_seen = 0;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic start_cfg(input logic [7:0] taps);
        cfg_taps = taps;
        cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
    endtask

    task automatic wait_x_ready(input string nm, input int budget);
        int i;
        for (i = 0; i < budget && !x_tready; i++) @(negedge clk);
        check(nm, 64'(x_tready), 64'd1);
    endtask

    task automatic wait_error(input string nm, input int budget);
        int i;
        for (i = 0; i < budget && !error; i++) @(negedge clk);
        check(nm, 64'(error), 64'd1);
    endtask

    task automatic check_sb_empty(input string nm);
        check(nm, 64'(exp_wr.size() + exp_rd.size() + exp_y.size()), 64'd0);
    endtask

    initial begin : stim
        int i, lat, rd0, aw0, ar0;
        // Reset state, sampled while rst is held and after release.
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
              bus.rready, coeff_tready, x_tready, y_tvalid, busy, error}), 64'd0);
        rst = 0;
        @(negedge clk);
        check("idle_outputs", 64'({bus.awvalid, bus.arvalid, coeff_tready, x_tready,
              y_tvalid, busy, error}), 64'd0);
        check("fixed_strb_prot", 64'({bus.wstrb, bus.awprot, bus.arprot}), 64'h0F << 6);

        // 3 taps, awready delayed 3 cycles on every write; then one sample with Y on 4th poll.
        aw_delay = 3;
        coeff_src.push_back(32'd1); coeff_src.push_back(32'd2); coeff_src.push_back(32'd3);
        push_wr(8'h04, 32'd3); push_wr(8'h08, 32'd1); push_wr(8'h08, 32'd2);
        push_wr(8'h08, 32'd3); push_wr(8'h00, 32'd1);
        exp_rd.push_back(AW'(8'h10));
        start_cfg(8'd3);
        busy_watch = 1;
        wait_x_ready("cfg3_reach_get_x", 300);
        check_sb_empty("cfg3_sb_empty");
        y_on = 4; y_val = 32'h2A; y_tready = 0;
        push_wr(8'h0C, 32'd5);
        for (i = 0; i < 4; i++) exp_rd.push_back(AW'(8'h10));
        exp_rd.push_back(AW'(8'h14));
        exp_y.push_back(32'h2A);
        x_src.push_back(32'd5);
        for (i = 0; i < 300 && !y_tvalid; i++) @(negedge clk);
        check("y_valid_seen", 64'(y_tvalid), 64'd1);
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            check("y_hold_during_stall", 64'({y_tvalid, y_tdata}), 64'({1'b1, 32'h2A}));
        end
        @(posedge clk);
        #2 y_tready = 1;
        wait_x_ready("y_done_back_to_get_x", 20);
        check_sb_empty("sample_sb_empty");
        check("status_reads", 64'(st_reads), 64'd5);
        check("busy_throughout", 64'(busy_low_seen), 64'd0);
        check("no_error_cfg3", 64'(error), 64'd0);

        // 40 taps clamp to 16; then zero-wait latency of one sample.
        do_reset();
        for (i = 0; i < 20; i++) coeff_src.push_back(32'(100 + i));
        push_wr(8'h04, 32'd16);
        for (i = 0; i < 16; i++) push_wr(8'h08, 32'(100 + i));
        push_wr(8'h00, 32'd1);
        exp_rd.push_back(AW'(8'h10));
        start_cfg(8'd40);
        wait_x_ready("clamp_reach_get_x", 500);
        check("clamp_coeffs_used", 64'(coeff_used), 64'd16);
        check("clamp_coeffs_left", 64'(coeff_src.size()), 64'd4);
        check_sb_empty("clamp_sb_empty");
        y_on = 1; y_val = 32'h99;
        push_wr(8'h0C, 32'h11);
        exp_rd.push_back(AW'(8'h10)); exp_rd.push_back(AW'(8'h14));
        exp_y.push_back(32'h99);
        x_src.push_back(32'h11);
        for (i = 0; i < 20 && !(x_tvalid && x_tready); i++) @(negedge clk);
        lat = 0;
        while (!y_tvalid && lat < 50) begin @(negedge clk); lat++; end
        check("x_to_y_latency_le_12", 64'(lat >= 1 && lat <= 12), 64'd1);
        wait_x_ready("latency_back_to_get_x", 20);
        check_sb_empty("latency_sb_empty");

        // Error response on the second COEFF write.
        do_reset();
        bad_wr_idx = 2;
        coeff_src.push_back(32'd7); coeff_src.push_back(32'd8);
        push_wr(8'h04, 32'd2); push_wr(8'h08, 32'd7); push_wr(8'h08, 32'd8);
        start_cfg(8'd2);
        wait_error("bresp_error", 200);
        aw0 = aw_total; ar0 = ar_total;
        repeat (20) @(negedge clk);
        check("err_no_new_aw", 64'(aw_total), 64'(aw0));
        check("err_no_new_ar", 64'(ar_total), 64'(ar0));
        check("err_quiet_busy", 64'({bus.awvalid, bus.wvalid, bus.arvalid, coeff_tready,
              x_tready, busy, error}), 64'b0000011);
        check_sb_empty("err_sb_empty");

        // N=0 skips COEFF/POLL_LOAD; STATUS never ready -> error after 8 reads.
        do_reset();
        push_wr(8'h04, 32'd0); push_wr(8'h00, 32'd1);
        start_cfg(8'd0);
        wait_x_ready("n0_reach_get_x", 100);
        check("n0_no_load_poll", 64'(st_reads), 64'd0);
        push_wr(8'h0C, 32'd7);
        for (i = 0; i < 8; i++) exp_rd.push_back(AW'(8'h10));
        x_src.push_back(32'd7);
        wait_error("poll_limit_error", 300);
        rd0 = st_reads;
        repeat (10) @(negedge clk);
        check("poll_limit_reads", 64'(st_reads), 64'd8);
        check("poll_no_more_reads", 64'(st_reads), 64'(rd0));
        check_sb_empty("poll_sb_empty");

        // Reset asserted while the X write is in flight.
        do_reset();
        aw_delay = 3;
        coeff_src.push_back(32'd9);
        push_wr(8'h04, 32'd1); push_wr(8'h08, 32'd9); push_wr(8'h00, 32'd1);
        exp_rd.push_back(AW'(8'h10));
        start_cfg(8'd1);
        wait_x_ready("rst_test_reach_get_x", 200);
        x_src.push_back(32'd3);
        for (i = 0; i < 50 && !(bus.awvalid && bus.awaddr == AW'(8'h0C)); i++) @(negedge clk);
        check("wr_x_in_flight", 64'(bus.awvalid && bus.awaddr == AW'(8'h0C)), 64'd1);
        rst = 1;
        #1;
        check("async_rst_drops_valids", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
              bus.rready, x_tready, y_tvalid, busy}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", 64'({busy, error, bus.awvalid, bus.arvalid, x_tready}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
